// File: rtl/lzc_pkg.sv
// Definitions shared by the lzc leading-zero counter and the lzc_gen pattern generator.
package lzc_pkg;

    localparam int WIDTH = 8;
    localparam int WORD  = 4;
    localparam int FW    = WIDTH * WORD;
    localparam int ZW    = $clog2(WIDTH * WORD) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic MODE_ONES   = 1'b0;
    localparam logic MODE_ONEHOT = 1'b1;

endpackage

// File: rtl/lzc_byte_pat.sv
// Combinational byte slice of a leading-zero frame: byte idx of a frame with zq
// leading zeros, a single one, then ~mq fill. zq == FW yields an all-zero frame.
module lzc_byte_pat #(
    parameter int width = 8,
    parameter int ZWL   = 6,
    parameter int IW    = 2
) (
    input  logic [ZWL-1:0]   zq,
    input  logic             mq,
    input  logic [IW-1:0]    idx,
    output logic [width-1:0] pat
);

    logic [31:0] zq_w;
    assign zq_w = 32'(zq);

    // Output bit width-1-gi sits at frame position idx*width+gi (MSB-first).
    for (genvar gi = 0; gi < width; gi++) begin : g_bit
        logic [31:0] pos;
        assign pos = 32'(idx) * 32'(width) + 32'(gi);
        assign pat[width-1-gi] = (pos < zq_w)  ? 1'b0 :
                                 (pos == zq_w) ? 1'b1 : ~mq;
    end

endmodule

// File: rtl/lzc_gen.sv
// Leading-zero pattern generator: one request yields word registered bytes,
// MSB first, with a back-to-back accept window on the last byte.
module lzc_gen
    import lzc_pkg::*;
#(
    parameter int width = WIDTH,
    parameter int word  = WORD
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [$clog2(width*word):0]     zeros,
    input  logic                            Ivalid,
    input  logic                            mode,
    output logic                            ready,
    output logic [width-1:0]                data,
    output logic                            Ovalid
);

    localparam int FWL = width * word;
    localparam int ZWL = $clog2(FWL) + 1;
    localparam int IW  = (word > 1) ? $clog2(word) : 1;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [ZWL-1:0]   zq_q, zq_d;
    logic             mq_q, mq_d;
    logic [width-1:0] data_q, data_d;
    logic             ovalid_q, ovalid_d;

    logic             last;
    logic [ZWL-1:0]   zeros_sat;
    logic [width-1:0] pat;

    assign last      = (idx_q == IW'(word - 1));
    assign ready     = (state_q == IDLE) || last;
    assign zeros_sat = (zeros > ZWL'(FWL)) ? ZWL'(FWL) : zeros;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        zq_d     = zq_q;
        mq_d     = mq_q;
        ovalid_d = 1'b0;
        if (Ivalid && ready) begin
            state_d  = SEND;
            idx_d    = '0;
            zq_d     = zeros_sat;
            mq_d     = mode;
            ovalid_d = 1'b1;
        end else if (state_q == SEND) begin
            if (last) begin
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                idx_d    = idx_q + IW'(1);
                ovalid_d = 1'b1;
            end
        end
    end

    // The pattern is evaluated on next-state values so the byte lands in data_q
    // in the same cycle its index becomes current.
    lzc_byte_pat #(
        .width (width),
        .ZWL   (ZWL),
        .IW    (IW)
    ) u_pat (
        .zq  (zq_d),
        .mq  (mq_d),
        .idx (idx_d),
        .pat (pat)
    );

    assign data_d = ovalid_d ? pat : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            zq_q     <= '0;
            mq_q     <= 1'b0;
            data_q   <= '0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            zq_q     <= zq_d;
            mq_q     <= mq_d;
            data_q   <= data_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign data   = data_q;
    assign Ovalid = ovalid_q;

endmodule

// File: tb/tb_lzc_gen.sv
// Scoreboard bench for lzc_gen: stimulus pushes expected bytes and zero counts,
// a negedge monitor pops and compares whenever Ovalid is high.
module tb_lzc_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] zeros;
    logic       Ivalid;
    logic       mode;
    logic       ready;
    logic [7:0] data;
    logic       Ovalid;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q[$];
    int         lz_q[$];

    lzc_gen #(.width(8), .word(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .zeros  (zeros),
        .Ivalid (Ivalid),
        .mode   (mode),
        .ready  (ready),
        .data   (data),
        .Ovalid (Ovalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] frame, input int lz);
        logic [31:0] f;
        f = frame;
        for (int k = 0; k < 4; k++) exp_q.push_back(f[31-8*k -: 8]);
        lz_q.push_back(lz);
    endtask

    // Presents a request for one cycle; returns #1 after the accepting edge.
    task automatic issue(input logic [5:0] z, input logic m, input logic [31:0] frame, input int lz);
        check("ready_before_req", {31'd0, ready}, 32'd1);
        zeros  = z;
        mode   = m;
        Ivalid = 1'b1;
        push_exp(frame, lz);
        $display("req zeros=%0d mode=%0d expect frame %08h", z, m, frame);
        tick();
        Ivalid = 1'b0;
    endtask

    // Monitor: byte-level compare plus a leading-zero count of each full frame.
    logic [31:0] frame_acc;
    int          nb = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            nb = 0;
        end else if (Ovalid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_byte: got %02h, expected no byte", data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("data", {24'd0, data}, {24'd0, e});
            end
            frame_acc = {frame_acc[23:0], data};
            nb++;
            if (nb == 4) begin
                int lz;
                nb = 0;
                lz = 32;
                for (int i = 31; i >= 0; i--) begin
                    if (frame_acc[i]) begin
                        lz = 31 - i;
                        break;
                    end
                end
                if (lz_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_frame: got %08h, expected no frame", frame_acc);
                end else begin
                    int el;
                    el = lz_q.pop_front();
                    check("frame_lz", 32'(lz), 32'(el));
                end
            end
        end
    end

    typedef struct {
        logic [5:0]  z;
        logic        m;
        logic [31:0] f;
        int          lz;
    } vec_t;

    vec_t vecs[7] = '{
        '{6'd7,  1'b0, 32'h01FF_FFFF, 7},
        '{6'd10, 1'b1, 32'h0020_0000, 10},
        '{6'd0,  1'b1, 32'h8000_0000, 0},
        '{6'd32, 1'b0, 32'h0000_0000, 32},
        '{6'd40, 1'b1, 32'h0000_0000, 32},
        '{6'd40, 1'b0, 32'h0000_0000, 32},
        '{6'd0,  1'b0, 32'hFFFF_FFFF, 0}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        Ivalid = 1'b0;
        zeros  = '0;
        mode   = 1'b0;
        #12;
        check("reset_ready",  {31'd0, ready},  32'd1);
        check("reset_ovalid", {31'd0, Ovalid}, 32'd0);
        check("reset_data",   {24'd0, data},   32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Single isolated requests
        foreach (vecs[i]) begin
            issue(vecs[i].z, vecs[i].m, vecs[i].f, vecs[i].lz);
            repeat (4) tick();
            check("idle_ovalid", {31'd0, Ovalid}, 32'd0);
            check("idle_ready",  {31'd0, ready},  32'd1);
        end

        // Ivalid held high across two frames; mid-frame zeros/mode changes ignored
        zeros = 6'd8; mode = 1'b0; Ivalid = 1'b1;
        push_exp(32'h00FF_FFFF, 8);
        tick();
        for (int c = 0; c < 8; c++) begin
            check("b2b_ovalid", {31'd0, Ovalid}, 32'd1);
            if (c == 0) begin
                zeros = 6'd3; mode = 1'b1;
            end
            if (c == 3) begin
                check("b2b_ready_last", {31'd0, ready}, 32'd1);
                zeros = 6'd31; mode = 1'b1;
                push_exp(32'h0000_0001, 31);
            end
            if (c == 4) Ivalid = 1'b0;
            tick();
        end
        check("b2b_end_ovalid", {31'd0, Ovalid}, 32'd0);
        check("b2b_end_ready",  {31'd0, ready},  32'd1);

        // Single-cycle Ivalid pulse mid-frame is ignored
        issue(6'd12, 1'b0, 32'h000F_FFFF, 12);
        tick();
        check("pulse_ready_mid", {31'd0, ready}, 32'd0);
        zeros = 6'd0; mode = 1'b1; Ivalid = 1'b1;
        tick();
        Ivalid = 1'b0;
        repeat (2) tick();
        check("pulse_end_ovalid", {31'd0, Ovalid}, 32'd0);

        // Reset after two bytes drops the rest of the frame
        issue(6'd5, 1'b0, 32'h07FF_FFFF, 5);
        tick();
        @(negedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        lz_q.delete();
        #1;
        check("rst_mid_ovalid", {31'd0, Ovalid}, 32'd0);
        check("rst_mid_data",   {24'd0, data},   32'd0);
        check("rst_mid_ready",  {31'd0, ready},  32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("rst_rel_ovalid", {31'd0, Ovalid}, 32'd0);
        check("rst_rel_data",   {24'd0, data},   32'd0);
        issue(6'd20, 1'b1, 32'h0000_0800, 20);
        repeat (4) tick();

        // Sweeps 0..32 in both modes, back-to-back through the last-byte window
        for (int m = 0; m < 2; m++) begin
            for (int z = 0; z <= 32; z++) begin
                logic [31:0] f;
                if (z == 32)     f = 32'h0;
                else if (m == 0) f = 32'hFFFF_FFFF >> z;
                else             f = 32'h8000_0000 >> z;
                issue(6'(z), m[0], f, z);
                repeat (3) tick();
            end
            tick();
        end

        for (int w = 0; w < 20 && (exp_q.size() != 0 || lz_q.size() != 0); w++) tick();
        check("drain_bytes",  32'(exp_q.size()), 32'd0);
        check("drain_frames", 32'(lz_q.size()),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lzc_gen.md
# lzc_gen

Leading-zero pattern generator: the transmit-side counterpart of the `lzc` leading-zero counter. It accepts a zero count and streams `word` bytes of `width` bits, most-significant byte first, using the same `data`/`Ivalid`-style framing that `lzc` consumes. The concatenated `width*word`-bit value has exactly that many leading zeros. It drives `lzc` in loopback self-test and serves as a normalized-operand source.

## Interface
- `width`, 8, bits per output byte
- `word`, 4, bytes per frame; frame width `FW = width*word`
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `zeros`  in  `$clog2(width*word)+1`  requested leading-zero count, 0..FW
- `Ivalid`  in  1  request strobe; sampled only when `ready`=1
- `mode`  in  1  fill after the leading one: 0 = ones, 1 = zeros (one-hot)
- `ready`  out  1  request can be accepted this cycle
- `data`  out  `width`  current output byte
- `Ovalid`  out  1  `data` valid this cycle

## Operation
- States:
  - IDLE: `ready`=1, `Ovalid`=0, `data`=0.
  - SEND: emits bytes, byte index `idx` runs 0..word-1.
- Accept: on a rising edge with `Ivalid`=1 and `ready`=1.
  - Latch `zeros` into `zq`, saturating values above FW to FW.
  - Latch `mode` into `mq`.
  - Set `idx`=0 and go to SEND.
- Bit rule, for frame bit position p (0 = MSB of byte 0):
  - p < zq: bit = 0
  - p == zq: bit = 1
  - p > zq: bit = ~mq
  - zq == FW: whole frame is 0, no leading one.
- Byte k holds bit positions k*width .. k*width+width-1, MSB first.
- SEND, each cycle: `Ovalid`=1 and `data` = byte `idx`. `idx` increments each cycle.
- At `idx`=word-1, `ready`=1 (back-to-back window).
  - If `Ivalid`=1: latch a new request, set `idx`=0, stay in SEND.
  - Otherwise: go to IDLE.
- `Ivalid` while `ready`=0 is ignored. The in-flight frame is never altered by `zeros`/`mode` changes.
- Reset (async assert, any state): state IDLE, `idx`=0, `zq`=0, `mq`=0, `data`=0, `Ovalid`=0. Because `ready` is decoded from state, `ready` reads 1 during reset. A partial frame is dropped with no further bytes.

## Timing
- All outputs are registered except `ready`, which is decoded from state/`idx`.
- Latency: request accepted at edge N, byte 0 valid in cycle N+1, byte word-1 valid in cycle N+word.
- Throughput: one frame per `word` cycles with `Ivalid` held high; no idle gap between frames.
- `Ovalid` is high for exactly `word` consecutive cycles per accepted request.
- Frame byte output order matches what `lzc` expects.

## Structure
- Shared package `lzc_pkg` holds:
  - Parameter defaults `WIDTH`=8, `WORD`=4.
  - `ZW = $clog2(WIDTH*WORD)+1`.
  - State enum {IDLE, SEND}.
  - Mode encoding constants `MODE_ONES`=0, `MODE_ONEHOT`=1.
  - All shared with `lzc`.
- One sub-module `lzc_byte_pat` (combinational): inputs `zq`, `mq`, `idx`; output one `width`-bit byte per the bit rule. Reusable by the `lzc` bench as a reference model.
- Top level holds the FSM, `idx` counter, request registers and output registers.

## Test plan
- zeros=7, mode=0, single request -> `Ovalid` for 4 cycles, data 0x01, 0xFF, 0xFF, 0xFF; then `ready`=1, `Ovalid`=0.
- zeros=10, mode=1 -> 0x00, 0x20, 0x00, 0x00; zeros=0, mode=1 -> 0x80, 0x00, 0x00, 0x00.
- zeros=32 and zeros=40 (saturation), either mode -> 0x00 x4 each.
- `Ivalid` held high for two requests (zeros=8, mode=0 then zeros=31, mode=1):
  - 8 consecutive `Ovalid` cycles: 0x00, 0xFF, 0xFF, 0xFF, 0x00, 0x00, 0x00, 0x01.
  - An `Ivalid` pulse mid-frame is ignored.
- `rst_n` asserted after 2 bytes of a frame -> `Ovalid`=0 and `data`=0 immediately and after release; the next request emits a full fresh frame.
- Loopback into `lzc` (mode=0), zeros swept 0..32 -> `lzc` `zeros` output equals the generator input for every value.
